// File: rtl/ysyx_23060020_ifu.sv
// Instruction fetch unit: holds the PC, issues one instruction-memory read at a time
// and hands each fetched word to decode over a valid/ready handshake.
module ysyx_23060020_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_arvalid,
    output logic [31:0] imem_araddr,
    input  logic        imem_arready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rerr,
    output logic        imem_rready,
    output logic        inst_valid,
    output logic [31:0] instw,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      r_state,     w_stateNext;
    logic [31:0] r_pc,        w_pcNext;
    logic        r_kill,      w_killNext;
    logic        r_pendValid, w_pendValidNext;
    logic [31:0] r_pendPc,    w_pendPcNext;
    logic [31:0] r_instw,     w_instwNext;
    logic [31:0] r_instPc,    w_instPcNext;
    logic        r_fault,     w_faultNext;
    logic        r_drain,     w_drainNext;
    logic        r_started;

    logic w_misaligned;
    logic w_arFire;

    // r_started keeps arvalid low for the first cycle out of reset so every output stays registered
    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign imem_arvalid = (r_state == S_REQ) && r_started && !w_misaligned;
    assign imem_araddr  = r_pc;
    assign imem_rready  = (r_state == S_WAIT) || ((r_state == S_HALT) && r_drain);
    assign inst_valid   = (r_state == S_HOLD);
    assign instw        = r_instw;
    assign inst_pc      = r_instPc;
    assign fetch_fault  = r_fault;
    assign w_arFire     = imem_arvalid && imem_arready;

    always_comb begin
        w_stateNext     = r_state;
        w_pcNext        = r_pc;
        w_killNext      = r_kill;
        w_pendValidNext = r_pendValid;
        w_pendPcNext    = r_pendPc;
        w_instwNext     = r_instw;
        w_instPcNext    = r_instPc;
        w_faultNext     = r_fault;
        w_drainNext     = r_drain;

        if (halt_req && (r_state != S_HALT)) begin
            // A request already on the bus must still have its response absorbed in HALT
            w_stateNext = S_HALT;
            w_drainNext = ((r_state == S_WAIT) && !imem_rvalid) || ((r_state == S_REQ) && w_arFire);
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect_valid) begin
                        w_pendPcNext    = redirect_pc;
                        w_pendValidNext = 1'b1;
                        w_killNext      = 1'b1;
                    end
                    if (r_started) begin
                        if (w_misaligned) begin
                            w_faultNext = 1'b1;
                            w_stateNext = S_HALT;
                        end else if (imem_arready) begin
                            w_stateNext = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill || redirect_valid) begin
                            // A redirect arriving with the response wins over any older pending target
                            w_killNext      = 1'b0;
                            w_pendValidNext = 1'b0;
                            w_pcNext        = redirect_valid ? redirect_pc : r_pendPc;
                            w_stateNext     = S_REQ;
                        end else if (imem_rerr) begin
                            w_faultNext = 1'b1;
                            w_stateNext = S_HALT;
                        end else begin
                            w_instwNext  = imem_rdata;
                            w_instPcNext = r_pc;
                            w_stateNext  = S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        w_pendPcNext    = redirect_pc;
                        w_pendValidNext = 1'b1;
                        w_killNext      = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (inst_ready || redirect_valid) begin
                        w_pcNext    = redirect_valid ? redirect_pc : (r_pc + 32'd4);
                        w_stateNext = S_REQ;
                    end
                end
                S_HALT: begin
                    if (r_drain && imem_rvalid) begin
                        w_drainNext = 1'b0;
                    end
                end
                default: w_stateNext = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_pendValid <= 1'b0;
            r_pendPc    <= 32'd0;
            r_instw     <= 32'd0;
            r_instPc    <= 32'd0;
            r_fault     <= 1'b0;
            r_drain     <= 1'b0;
            r_started   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_kill      <= w_killNext;
            r_pendValid <= w_pendValidNext;
            r_pendPc    <= w_pendPcNext;
            r_instw     <= w_instwNext;
            r_instPc    <= w_instPcNext;
            r_fault     <= w_faultNext;
            r_drain     <= w_drainNext;
            r_started   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_23060020_ifu.sv
// Bench for ysyx_23060020_ifu: directed scenarios, then randomized memory/decode traffic
// checked by a scoreboard against a transaction-level model of the fetch stream.
module tb_ysyx_23060020_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_arvalid;
    logic [31:0] imem_araddr;
    logic        imem_arready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_rerr;
    logic        imem_rready;
    logic        inst_valid;
    logic [31:0] instw;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fetch_fault;

    always #5 clk = ~clk;

    ysyx_23060020_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .imem_arvalid(imem_arvalid),
        .imem_araddr(imem_araddr),
        .imem_arready(imem_arready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .imem_rerr(imem_rerr),
        .imem_rready(imem_rready),
        .inst_valid(inst_valid),
        .instw(instw),
        .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .fetch_fault(fetch_fault)
    );

    int compared = 0;
    int mismatched = 0;

    logic [31:0] expReqQ[$];
    logic [63:0] expInstQ[$];
    bit          scoreOn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic arready, input logic rvalid, input logic [31:0] rdata,
                                 input logic rerr, input logic iready, input logic redir,
                                 input logic [31:0] rpc, input logic halt);
        imem_arready   = arready;
        imem_rvalid    = rvalid;
        imem_rdata     = rdata;
        imem_rerr      = rerr;
        inst_ready     = iready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        halt_req       = halt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    // Reset for two edges; returns in the first cycle with rst low
    task automatic resetDut();
        idleInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Scoreboard monitor: compares whenever a request is accepted or an instruction leaves decode's input
    always @(negedge clk) begin
        if (scoreOn) begin
            if (imem_arvalid && imem_arready) begin
                if (expReqQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedRequest: got araddr %h, expected no request", imem_araddr);
                end else begin
                    checkOutput("araddr", imem_araddr, expReqQ.pop_front());
                end
            end
            if (inst_valid && (inst_ready || redirect_valid)) begin
                if (expInstQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedInst: got pc %h instw %h, expected none", inst_pc, instw);
                end else begin
                    logic [63:0] e;
                    e = expInstQ.pop_front();
                    checkOutput("inst_pc", inst_pc, e[63:32]);
                    checkOutput("instw", instw, e[31:0]);
                end
            end
        end
    end

    logic [31:0] fetchPc, pendTgt, outAddr, tgt, rd;
    bit          pendValid, outstanding, arv, rr, iv, aRdy, rv, re, iRdy, redir, respHs, acc;
    int          delay, idle;

    initial begin
        rst = 1'b1;
        idleInputs();

        // Reset values and zero-wait first fetch
        tick();
        tick();
        checkOutput("rstArvalid", imem_arvalid, 0);
        checkOutput("rstRready", imem_rready, 0);
        checkOutput("rstInstValid", inst_valid, 0);
        checkOutput("rstInstw", instw, 0);
        checkOutput("rstInstPc", inst_pc, 0);
        checkOutput("rstFault", fetch_fault, 0);
        rst = 1'b0;
        checkOutput("rstReleaseArvalid", imem_arvalid, 0);
        tick();
        checkOutput("firstArvalid", imem_arvalid, 1);
        checkOutput("firstAraddr", imem_araddr, RESET_PC);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("waitArvalid", imem_arvalid, 0);
        checkOutput("waitRready", imem_rready, 1);
        applyStimulus(1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("holdValid", inst_valid, 1);
        checkOutput("holdInstw", instw, 32'h0010_0093);
        checkOutput("holdInstPc", inst_pc, RESET_PC);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("nextArvalid", imem_arvalid, 1);
        checkOutput("nextAraddr", imem_araddr, 32'h8000_0004);

        // Back-pressure on the request, then a slow response
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            checkOutput("stallArvalid", imem_arvalid, 1);
            checkOutput("stallAraddr", imem_araddr, 32'h8000_0004);
            tick();
        end
        checkOutput("stallAraddrAccept", imem_araddr, 32'h8000_0004);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            idleInputs();
            checkOutput("slowNoValid", inst_valid, 0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 32'h0020_8113, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("slowRvalidCycle", inst_valid, 0);
        tick();
        checkOutput("slowValid", inst_valid, 1);
        checkOutput("slowInstw", instw, 32'h0020_8113);
        checkOutput("slowInstPc", inst_pc, 32'h8000_0004);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();

        // Redirect while waiting drops the in-flight response
        checkOutput("killAraddr", imem_araddr, 32'h8000_0008);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("killNoValid", inst_valid, 0);
        checkOutput("killArvalid", imem_arvalid, 1);
        checkOutput("killAraddr2", imem_araddr, 32'h8000_0100);

        // Consume with redirect in HOLD: redirect target wins over pc+4
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("redirHoldPc", inst_pc, 32'h8000_0100);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h8000_0020, 1'b0);
        tick();
        checkOutput("redirArvalid", imem_arvalid, 1);
        checkOutput("redirAraddr", imem_araddr, 32'h8000_0020);

        // Access error halts until reset
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("errFault", fetch_fault, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
            checkOutput("errArvalid", imem_arvalid, 0);
            tick();
        end
        idleInputs();
        rst = 1'b1;
        tick();
        checkOutput("errFaultCleared", fetch_fault, 0);
        rst = 1'b0;
        tick();
        checkOutput("errRefetchArvalid", imem_arvalid, 1);
        checkOutput("errRefetchAraddr", imem_araddr, RESET_PC);

        // Misaligned redirect target faults without issuing a request
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h8000_0002, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("misArvalid", imem_arvalid, 0);
        tick();
        checkOutput("misFault", fetch_fault, 1);
        checkOutput("misArvalidHalt", imem_arvalid, 0);
        tick();
        checkOutput("misArvalidStay", imem_arvalid, 0);

        // halt_req while holding an instruction
        resetDut();
        tick();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("haltHoldValid", inst_valid, 1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        checkOutput("haltInstValid", inst_valid, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
            checkOutput("haltArvalid", imem_arvalid, 0);
            tick();
        end
        checkOutput("haltNoFault", fetch_fault, 0);

        // halt_req with a request outstanding drains one response
        resetDut();
        tick();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        checkOutput("drainRready", imem_rready, 1);
        checkOutput("drainArvalid", imem_arvalid, 0);
        idleInputs();
        tick();
        checkOutput("drainRreadyHeld", imem_rready, 1);
        applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("drainDone", imem_rready, 0);
        checkOutput("drainNoValid", inst_valid, 0);

        // Randomized traffic checked by the scoreboard
        resetDut();
        fetchPc     = RESET_PC;
        pendValid   = 1'b0;
        pendTgt     = 32'd0;
        outstanding = 1'b0;
        outAddr     = 32'd0;
        delay       = 0;
        idle        = 0;
        scoreOn     = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            arv   = imem_arvalid;
            rr    = imem_rready;
            iv    = inst_valid;
            aRdy  = ($urandom_range(0, 9) < 6);
            rv    = 1'b0;
            rd    = 32'd0;
            re    = 1'b0;
            if (outstanding && delay == 0) begin
                rv = 1'b1;
                rd = memWord(outAddr);
            end else if (!outstanding && $urandom_range(0, 9) == 0) begin
                rv = 1'b1;
                rd = $urandom;
                re = 1'($urandom_range(0, 1));
            end
            iRdy  = iv ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
            redir = iv ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            tgt   = RESET_PC + 32'($urandom_range(0, 255)) * 32'd4;
            applyStimulus(aRdy, rv, rd, re, iRdy, redir, tgt, 1'b0);

            // Model: the latest redirect before a response kills it; held instructions advance pc
            if (redir && !iv) begin
                pendValid = 1'b1;
                pendTgt   = tgt;
            end
            acc = arv && aRdy;
            if (acc) expReqQ.push_back(fetchPc);
            respHs = outstanding && (delay == 0) && rr;
            if (respHs) begin
                if (pendValid) begin
                    fetchPc   = pendTgt;
                    pendValid = 1'b0;
                end else begin
                    expInstQ.push_back({fetchPc, memWord(fetchPc)});
                end
            end
            if (iv && (iRdy || redir)) fetchPc = redir ? tgt : (fetchPc + 32'd4);

            if (respHs || acc) idle = 0;
            else idle++;
            if (idle > 60) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL progressTimeout: got %0d idle cycles, expected at most 60", idle);
                break;
            end
            if (acc) outAddr = imem_araddr;
            tick();
            if (respHs) outstanding = 1'b0;
            if (acc) begin
                outstanding = 1'b1;
                delay       = $urandom_range(0, 2);
            end else if (outstanding && delay > 0) begin
                delay--;
            end
        end
        idleInputs();
        @(posedge clk);
        scoreOn = 1'b0;
        checkOutput("reqQueueDrained", expReqQ.size(), 0);
        checkOutput("instQueueDepthOk", (expInstQ.size() > 1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
